// File: rtl/writeback_arbiter_pkg.sv
// Shared constants for the writeback return path: widths, the one-hot unit codes the issue
// stage decodes, source indices and small arbitration helpers.
package writeback_arbiter_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 3;

    localparam logic [2:0] UNIT_INT = 3'b001;
    localparam logic [2:0] UNIT_VEC = 3'b010;
    localparam logic [2:0] UNIT_LSU = 3'b100;
    localparam logic [2:0] UNIT_NONE = 3'b000;

    // Source index doubles as the bit position of its unit code.
    typedef enum logic [1:0] {
        SRC_INT = 2'd0,
        SRC_VEC = 2'd1,
        SRC_LSU = 2'd2
    } src_t;

    function automatic logic [2:0] unit_code(input src_t s);
        case (s)
            SRC_VEC: return UNIT_VEC;
            SRC_LSU: return UNIT_LSU;
            default: return UNIT_INT;
        endcase
    endfunction

    function automatic src_t next_src(input src_t s);
        case (s)
            SRC_INT: return SRC_VEC;
            SRC_VEC: return SRC_LSU;
            default: return SRC_INT;
        endcase
    endfunction

    // One-hot grant to the first requester in the order a, b, c.
    function automatic logic [NUM_SRC-1:0] pick_first(input logic [NUM_SRC-1:0] req,
                                                      input src_t a, input src_t b, input src_t c);
        logic [NUM_SRC-1:0] g;
        g = '0;
        if (req[a])      g[a] = 1'b1;
        else if (req[b]) g[b] = 1'b1;
        else if (req[c]) g[c] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result handshakes from the INT/VEC/LSU units plus the registered writeback port.
// master = execution units and regfile side, slave = the arbiter.
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic              int_valid_in;
    logic [REG_AW-1:0] int_rd_in;
    logic [XLEN-1:0]   int_data_in;
    logic              int_ready_out;

    logic              vec_valid_in;
    logic [REG_AW-1:0] vec_rd_in;
    logic [XLEN-1:0]   vec_data_in;
    logic              vec_ready_out;

    logic              lsu_valid_in;
    logic [REG_AW-1:0] lsu_rd_in;
    logic [XLEN-1:0]   lsu_data_in;
    logic              lsu_ready_out;

    logic              wb_ready_in;
    logic              wb_valid_out;
    logic              wb_we_out;
    logic [REG_AW-1:0] wb_rd_out;
    logic [XLEN-1:0]   wb_data_out;
    logic [2:0]        wb_src_out;

    modport master (
        output int_valid_in, int_rd_in, int_data_in,
        output vec_valid_in, vec_rd_in, vec_data_in,
        output lsu_valid_in, lsu_rd_in, lsu_data_in,
        output wb_ready_in,
        input  int_ready_out, vec_ready_out, lsu_ready_out,
        input  wb_valid_out, wb_we_out, wb_rd_out, wb_data_out, wb_src_out
    );

    modport slave (
        input  int_valid_in, int_rd_in, int_data_in,
        input  vec_valid_in, vec_rd_in, vec_data_in,
        input  lsu_valid_in, lsu_rd_in, lsu_data_in,
        input  wb_ready_in,
        output int_ready_out, vec_ready_out, lsu_ready_out,
        output wb_valid_out, wb_we_out, wb_rd_out, wb_data_out, wb_src_out
    );

endinterface

// File: rtl/wb_hold_buffer.sv
// One-entry result holding buffer (full flag, rd, data). A load in the same cycle as a
// drain keeps the entry full, so a source can stream one result per cycle.
module wb_hold_buffer
    import writeback_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic [REG_AW-1:0] wr_rd,
    input  logic [XLEN-1:0]   wr_data,
    output logic              full,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   data
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            // NOTE: the payload is reset too; with one entry it is cheap and keeps outputs defined.
            rd   <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            rd   <= wr_rd;
            data <= wr_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Serialises INT/VEC/LSU results into one registered writeback port toward the regfile.
// Fixed priority LSU > INT > VEC by default; `WB_ROUND_ROBIN_EN selects a rotating pointer.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
(
    input  logic                clock_in,
    input  logic                reset_in,
    writeback_arbiter_if.slave  bus
);

    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] ready;
    logic [REG_AW-1:0]  src_rd   [NUM_SRC];
    logic [XLEN-1:0]    src_data [NUM_SRC];
    logic [REG_AW-1:0]  buf_rd   [NUM_SRC];
    logic [XLEN-1:0]    buf_data [NUM_SRC];
    logic               out_free;
    src_t               gnt_src;

    logic              wb_valid;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [2:0]        wb_src;

    assign src_valid          = {bus.lsu_valid_in, bus.vec_valid_in, bus.int_valid_in};
    assign src_rd[SRC_INT]    = bus.int_rd_in;
    assign src_rd[SRC_VEC]    = bus.vec_rd_in;
    assign src_rd[SRC_LSU]    = bus.lsu_rd_in;
    assign src_data[SRC_INT]  = bus.int_data_in;
    assign src_data[SRC_VEC]  = bus.vec_data_in;
    assign src_data[SRC_LSU]  = bus.lsu_data_in;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_buf
        wb_hold_buffer u_buf (
            .clk     (clock_in),
            .rst_n   (reset_in),
            .load    (src_valid[i] & ready[i]),
            .drain   (grant[i]),
            .wr_rd   (src_rd[i]),
            .wr_data (src_data[i]),
            .full    (full[i]),
            .rd      (buf_rd[i]),
            .data    (buf_data[i])
        );
    end

    assign out_free = !wb_valid || bus.wb_ready_in;

`ifdef WB_ROUND_ROBIN_EN
    src_t ptr;

    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        grant = '0;
        if (out_free) begin
            case (ptr)
                SRC_VEC: grant = pick_first(full, SRC_VEC, SRC_LSU, SRC_INT);
                SRC_LSU: grant = pick_first(full, SRC_LSU, SRC_INT, SRC_VEC);
                default: grant = pick_first(full, SRC_INT, SRC_VEC, SRC_LSU);
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in)   ptr <= SRC_INT;
        else if (|grant) ptr <= next_src(gnt_src);
    end
`else
    assign grant = out_free ? pick_first(full, SRC_LSU, SRC_INT, SRC_VEC) : '0;
`endif

    // A granted buffer can refill in the same cycle it drains.
    assign ready = ~full | grant;

    always_comb begin
        gnt_src = SRC_INT;
        if (grant[SRC_VEC]) gnt_src = SRC_VEC;
        if (grant[SRC_LSU]) gnt_src = SRC_LSU;
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_src   <= UNIT_NONE;
        end else if (|grant) begin
            wb_valid <= 1'b1;
            wb_we    <= (buf_rd[gnt_src] != '0);
            wb_rd    <= buf_rd[gnt_src];
            wb_data  <= buf_data[gnt_src];
            wb_src   <= unit_code(gnt_src);
        end else if (out_free) begin
            // Idle: rd/data keep their last value.
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_src   <= UNIT_NONE;
        end
    end

    assign bus.int_ready_out = ready[SRC_INT];
    assign bus.vec_ready_out = ready[SRC_VEC];
    assign bus.lsu_ready_out = ready[SRC_LSU];
    assign bus.wb_valid_out  = wb_valid;
    assign bus.wb_we_out     = wb_we;
    assign bus.wb_rd_out     = wb_rd;
    assign bus.wb_data_out   = wb_data;
    assign bus.wb_src_out    = wb_src;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } res_t;

    localparam int OUT_W = 2 + REG_AW + XLEN + 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    writeback_arbiter_if bus ();
    writeback_arbiter dut (.clock_in(clk), .reset_in(rst_n), .bus(bus));

    // Source 0 = INT, 1 = VEC, 2 = LSU.
    logic [2:0]        drv_valid;
    logic [REG_AW-1:0] drv_rd   [3];
    logic [XLEN-1:0]   drv_data [3];
    logic              drv_wb_ready;

    assign bus.int_valid_in = drv_valid[0];
    assign bus.int_rd_in    = drv_rd[0];
    assign bus.int_data_in  = drv_data[0];
    assign bus.vec_valid_in = drv_valid[1];
    assign bus.vec_rd_in    = drv_rd[1];
    assign bus.vec_data_in  = drv_data[1];
    assign bus.lsu_valid_in = drv_valid[2];
    assign bus.lsu_rd_in    = drv_rd[2];
    assign bus.lsu_data_in  = drv_data[2];
    assign bus.wb_ready_in  = drv_wb_ready;

    // Reference model: results waiting per source, plus what the port currently shows.
    res_t              pend_q [3][$];
    logic              m_valid;
    logic              m_we;
    logic [REG_AW-1:0] m_rd;
    logic [XLEN-1:0]   m_data;
    logic [2:0]        m_src;
`ifdef WB_ROUND_ROBIN_EN
    int                m_ptr;
`endif
    int                m_pick;
    logic [2:0]        exp_ready;

    int n_cmp = 0;
    int n_err = 0;
    int n_accepted = 0;
    int dut_delivered = 0;

    function automatic int order_at(input int k);
`ifdef WB_ROUND_ROBIN_EN
        return (m_ptr + k) % 3;
`else
        case (k)
            0: return 2;
            1: return 0;
            default: return 1;
        endcase
`endif
    endfunction

    function automatic logic [OUT_W-1:0] obs_out();
        return {bus.wb_valid_out, bus.wb_we_out, bus.wb_rd_out, bus.wb_data_out, bus.wb_src_out};
    endfunction

    function automatic logic [OUT_W-1:0] exp_out();
        return {m_valid, m_we, m_rd, m_data, m_src};
    endfunction

    function automatic logic [2:0] obs_ready();
        return {bus.lsu_ready_out, bus.vec_ready_out, bus.int_ready_out};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pend_q[i].delete();
        m_valid = 1'b0;
        m_we    = 1'b0;
        m_rd    = '0;
        m_data  = '0;
        m_src   = 3'b000;
`ifdef WB_ROUND_ROBIN_EN
        m_ptr   = 0;
`endif
    endtask

    task automatic model_eval();
        logic free;
        free   = !m_valid || drv_wb_ready;
        m_pick = -1;
        if (free)
            for (int k = 0; k < 3; k++)
                if (m_pick < 0 && pend_q[order_at(k)].size() != 0) m_pick = order_at(k);
        for (int i = 0; i < 3; i++)
            exp_ready[i] = (pend_q[i].size() == 0) || (m_pick == i);
    endtask

    // Advance one clock edge; DUT and model both see the inputs driven before it.
    task automatic step();
        logic [2:0] acc;
        res_t       in_r [3];
        res_t       r;
        logic       free;
        int         pick;
        model_eval();
        free = !m_valid || drv_wb_ready;
        pick = m_pick;
        acc  = drv_valid & exp_ready;
        for (int i = 0; i < 3; i++) in_r[i] = {drv_rd[i], drv_data[i]};
        if (bus.wb_valid_out && drv_wb_ready) dut_delivered++;
        @(posedge clk);
        #1;
        if (pick >= 0) begin
            r       = pend_q[pick].pop_front();
            m_valid = 1'b1;
            m_we    = (r.rd != '0);
            m_rd    = r.rd;
            m_data  = r.data;
            m_src   = 3'(1 << pick);
`ifdef WB_ROUND_ROBIN_EN
            m_ptr   = (pick + 1) % 3;
`endif
        end else if (free) begin
            m_valid = 1'b0;
            m_we    = 1'b0;
            m_src   = 3'b000;
        end
        for (int i = 0; i < 3; i++) if (acc[i]) pend_q[i].push_back(in_r[i]);
        n_accepted += $countones(acc);
        model_eval();
    endtask

    task automatic do_reset();
        drv_valid    = '0;
        drv_wb_ready = 1'b1;
        rst_n        = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs_out() !== '0) begin
            n_err++; $display("FAIL reset_out got %h want 0", obs_out());
        end
        n_cmp++;
        if (obs_ready() !== 3'b111) begin
            n_err++; $display("FAIL reset_ready got %b want 111", obs_ready());
        end
        drv_wb_ready = 1'b0;
        drv_valid    = 3'b111;
        for (int i = 0; i < 3; i++) begin
            drv_rd[i]   = REG_AW'(i + 10);
            drv_data[i] = $urandom;
        end
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs_out() !== '0) begin
            n_err++; $display("FAIL reset_async_out got %h want 0", obs_out());
        end
        n_cmp++;
        if (obs_ready() !== 3'b111) begin
            n_err++; $display("FAIL reset_async_ready got %b want 111", obs_ready());
        end
        drv_valid    = '0;
        drv_wb_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_eval();
        n_cmp++;
        if (obs_out() !== '0 || obs_ready() !== 3'b111) begin
            n_err++; $display("FAIL reset_release got out=%h ready=%b want 0 / 111", obs_out(), obs_ready());
        end
    endtask

    task automatic test_single_int();
        do_reset();
        drv_valid    = 3'b001;
        drv_rd[0]    = 5;
        drv_data[0]  = 32'hDEADBEEF;
        step();
        drv_valid = '0;
        model_eval();
        #1;
        n_cmp++;
        if (bus.wb_valid_out !== 1'b0) begin
            n_err++; $display("FAIL single_early got valid=%b want 0", bus.wb_valid_out);
        end
        step();
        n_cmp++;
        if (obs_out() !== {1'b1, 1'b1, REG_AW'(5), 32'hDEADBEEF, 3'b001}) begin
            n_err++; $display("FAIL single_out got %h want valid/we/rd5/DEADBEEF/001", obs_out());
        end
        n_cmp++;
        if (obs_out() !== exp_out()) begin
            n_err++; $display("FAIL single_model got %h want %h", obs_out(), exp_out());
        end
        step();
        n_cmp++;
        if (bus.wb_valid_out !== 1'b0 || bus.wb_src_out !== 3'b000) begin
            n_err++; $display("FAIL single_once got valid=%b src=%b want 0/000", bus.wb_valid_out, bus.wb_src_out);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] seq [3];
`ifdef WB_ROUND_ROBIN_EN
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
`else
        seq[0] = 3'b100; seq[1] = 3'b001; seq[2] = 3'b010;
`endif
        do_reset();
        drv_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            drv_rd[i]   = REG_AW'(i + 1);
            drv_data[i] = $urandom;
        end
        #1;
        n_cmp++;
        if (obs_ready() !== 3'b111) begin
            n_err++; $display("FAIL simul_accept got ready=%b want 111", obs_ready());
        end
        step();
        drv_valid = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (bus.wb_valid_out !== 1'b1 || bus.wb_src_out !== seq[k]) begin
                n_err++; $display("FAIL simul_order[%0d] got valid=%b src=%b want 1/%b",
                                  k, bus.wb_valid_out, bus.wb_src_out, seq[k]);
            end
            n_cmp++;
            if (obs_out() !== exp_out()) begin
                n_err++; $display("FAIL simul_model[%0d] got %h want %h", k, obs_out(), exp_out());
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drv_wb_ready = 1'b0;
        drv_valid    = 3'b100;
        drv_rd[2]    = 7;
        drv_data[2]  = 32'hAAAA0001;
        step();
        drv_rd[2]   = 8;
        drv_data[2] = 32'hBBBB0002;
        step();
        drv_rd[2]   = 9;
        drv_data[2] = 32'hCCCC0003;
        for (int c = 0; c < 4; c++) begin
            model_eval();
            #1;
            n_cmp++;
            if (obs_out() !== {1'b1, 1'b1, REG_AW'(7), 32'hAAAA0001, 3'b100}) begin
                n_err++; $display("FAIL bp_hold[%0d] got %h want rd7/AAAA0001/100", c, obs_out());
            end
            n_cmp++;
            if (bus.lsu_ready_out !== 1'b0 || obs_ready() !== exp_ready) begin
                n_err++; $display("FAIL bp_ready[%0d] got %b want %b", c, obs_ready(), exp_ready);
            end
            step();
        end
        drv_wb_ready = 1'b1;
        model_eval();
        #1;
        n_cmp++;
        if (bus.lsu_ready_out !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready got %b want 1", bus.lsu_ready_out);
        end
        step();
        drv_valid = '0;
        n_cmp++;
        if (bus.wb_data_out !== 32'hBBBB0002 || obs_out() !== exp_out()) begin
            n_err++; $display("FAIL bp_next got %h want %h", obs_out(), exp_out());
        end
        step();
        n_cmp++;
        if (bus.wb_data_out !== 32'hCCCC0003 || bus.wb_valid_out !== 1'b1) begin
            n_err++; $display("FAIL bp_last got data=%h valid=%b want CCCC0003/1", bus.wb_data_out, bus.wb_valid_out);
        end
        step();
        n_cmp++;
        if (bus.wb_valid_out !== 1'b0) begin
            n_err++; $display("FAIL bp_idle got valid=%b want 0", bus.wb_valid_out);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        drv_valid   = 3'b010;
        drv_rd[1]   = 0;
        drv_data[1] = 32'h1234;
        step();
        drv_valid = '0;
        step();
        n_cmp++;
        if (obs_out() !== {1'b1, 1'b0, REG_AW'(0), 32'h1234, 3'b010}) begin
            n_err++; $display("FAIL rd_zero got %h want valid=1 we=0 rd0 1234 010", obs_out());
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] sent [8];
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                sent[c]     = $urandom;
                drv_valid   = 3'b001;
                drv_rd[0]   = REG_AW'(c + 1);
                drv_data[0] = sent[c];
                #1;
                n_cmp++;
                if (bus.int_ready_out !== 1'b1) begin
                    n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", c, bus.int_ready_out);
                end
            end else begin
                drv_valid = '0;
            end
            step();
            if (c >= 1 && c <= 8) begin
                n_cmp++;
                if (bus.wb_valid_out !== 1'b1 || bus.wb_data_out !== sent[c-1] ||
                    bus.wb_rd_out !== REG_AW'(c)) begin
                    n_err++; $display("FAIL b2b_out[%0d] got valid=%b rd=%0d data=%h want 1/%0d/%h",
                                      c - 1, bus.wb_valid_out, bus.wb_rd_out, bus.wb_data_out, c, sent[c-1]);
                end
            end
        end
        n_cmp++;
        if (bus.wb_valid_out !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle got valid=%b want 0", bus.wb_valid_out);
        end
    endtask

    task automatic test_random();
        int acc0;
        int del0;
        do_reset();
        acc0 = n_accepted;
        del0 = dut_delivered;
        for (int c = 0; c < 600; c++) begin
            drv_wb_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!drv_valid[i] && $urandom_range(0, 1) == 1) begin
                    drv_valid[i] = 1'b1;
                    drv_rd[i]    = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
                    drv_data[i]  = $urandom;
                end
            end
            model_eval();
            #1;
            n_cmp++;
            if (obs_ready() !== exp_ready) begin
                n_err++; $display("FAIL rand_ready[%0d] got %b want %b", c, obs_ready(), exp_ready);
            end
            n_cmp++;
            if (obs_out() !== exp_out()) begin
                n_err++; $display("FAIL rand_out[%0d] got %h want %h", c, obs_out(), exp_out());
            end
            begin
                logic [2:0] taken;
                taken = drv_valid & exp_ready;
                step();
                drv_valid = drv_valid & ~taken;
            end
        end
        drv_valid    = '0;
        drv_wb_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        n_cmp++;
        if ((dut_delivered - del0) !== (n_accepted - acc0)) begin
            n_err++; $display("FAIL rand_no_loss got %0d delivered want %0d", dut_delivered - del0, n_accepted - acc0);
        end
    endtask

    initial begin
        drv_valid    = '0;
        drv_wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_rd[i]   = '0;
            drv_data[i] = '0;
        end
        rst_n = 1'b0;
        test_reset();
        test_single_int();
        test_simultaneous();
        test_backpressure();
        test_rd_zero();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
